// File: rtl/random_pass_gen.sv
// Door-lock password generator: a free-running 32-bit Fibonacci LFSR whose state
// is latched into newPass on each enabled rising edge of unlockDoor.
module random_pass_gen #(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = 32'h00000001
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             keyEnable,
    input  logic             unlockDoor,
    output logic [WIDTH-1:0] newPass,
    output logic             passValid
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_next;
    logic             feedback;
    logic             unlock_prev;
    logic             capture;

    // x^32 + x^22 + x^2 + x + 1; an all-zero state is forced back to 1
    always_comb begin
        feedback  = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
        lfsr_next = (lfsr == '0) ? ONE : {lfsr[WIDTH-2:0], feedback};
        capture   = unlockDoor & ~unlock_prev & keyEnable;
    end

    // unlock_prev resets high so a request held through reset release is ignored
    always_ff @(posedge clk) begin
        if (!rstN) begin
            lfsr        <= SEED_EFF;
            unlock_prev <= 1'b1;
            newPass     <= '0;
            passValid   <= 1'b0;
        end else begin
            unlock_prev <= unlockDoor;
            if (keyEnable) begin
                lfsr <= lfsr_next;
            end
            if (capture) begin
                newPass <= lfsr;
            end
            passValid <= capture;
        end
    end

endmodule

// File: tb/tb_random_pass_gen.sv
// Directed bench for random_pass_gen: captured LFSR values are pushed to a
// scoreboard when an enabled rising unlock edge is driven, popped on passValid.
module tb_random_pass_gen;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        keyEnable = 1'b0;
    logic        unlockDoor = 1'b0;
    logic [31:0] newPass;
    logic        passValid;
    logic [31:0] newPass0;
    logic        passValid0;

    int unsigned compared = 0;
    int unsigned mismatched = 0;

    logic [31:0] sb[$];
    logic [31:0] m_lfsr = 32'h1;
    logic        m_prev = 1'b1;
    logic [31:0] m_pass = 32'h0;
    logic [31:0] last_cap = 32'h0;
    int unsigned pulses = 0;

    random_pass_gen #(.WIDTH(32), .SEED(32'h00000001)) dut (
        .clk(clk), .rstN(rstN), .keyEnable(keyEnable), .unlockDoor(unlockDoor),
        .newPass(newPass), .passValid(passValid)
    );

    random_pass_gen #(.WIDTH(32), .SEED(32'h00000000)) dut0 (
        .clk(clk), .rstN(rstN), .keyEnable(keyEnable), .unlockDoor(unlockDoor),
        .newPass(newPass0), .passValid(passValid0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic fb;
        if (s == 32'h0) return 32'h1;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic k, input logic u);
        logic fire;
        rstN = r;
        keyEnable = k;
        unlockDoor = u;
        fire = r && k && u && !m_prev;
        if (fire) sb.push_back(m_lfsr);
        @(posedge clk);
        #1;
        if (!r) begin
            m_lfsr = 32'h1;
            m_prev = 1'b1;
            m_pass = 32'h0;
            sb.delete();
        end else begin
            m_prev = u;
            if (k) m_lfsr = lfsr_step(m_lfsr);
            if (fire) m_pass = sb.pop_front();
        end
        chk("passValid", {31'b0, passValid}, {31'b0, fire});
        chk("newPass", newPass, m_pass);
        chk("lfsr", dut.lfsr, m_lfsr);
        if (passValid === 1'b1) pulses++;
    endtask

    initial begin
        // reset, then free-run
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("reset_lfsr", dut.lfsr, 32'h00000001);
        chk("zero_seed_lfsr", dut0.lfsr, 32'h00000001);
        chk("zero_seed_newPass", newPass0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("lfsr_after_3", dut.lfsr, 32'h0000000D);

        // capture and hold
        cycle(1'b1, 1'b1, 1'b1);
        chk("first_capture", newPass, 32'h0000000D);
        chk("lfsr_1b", dut.lfsr, 32'h0000001B);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1);
        chk("held_pass", newPass, 32'h0000000D);

        // keyEnable gating
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);

        // reset release with unlockDoor high
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("no_cap_after_reset", newPass, 32'h0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);

        // alternating unlockDoor
        cycle(1'b1, 1'b1, 1'b1);
        pulses = 0;
        last_cap = newPass;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, (i % 2 == 1));
            if (passValid === 1'b1) begin
                chk("cap_nonzero", {31'b0, (newPass != 32'h0)}, 32'h1);
                chk("cap_differs", {31'b0, (newPass != last_cap)}, 32'h1);
                last_cap = newPass;
            end
        end
        chk("alt_pulses", pulses, 32'd4);

        // mid-run reset restarts the sequence
        cycle(1'b0, 1'b1, 1'b0);
        chk("midreset_lfsr", dut.lfsr, 32'h00000001);
        chk("midreset_pass", newPass, 32'h0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("restart_1b", dut.lfsr, 32'h0000001B);
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
